// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Purpose : groups the fetch stage's memory read port, redirect request and
//           decode-side instruction handshake into one bundle.
// Signals :
//   mem_addr_o     word address driven to ADDR_2 of every memblock
//   mem_hit_i      OR of en2 from all memblocks for mem_addr_o (combinational)
//   mem_data_i     OR/mux of DOUT_2, valid the cycle after the address
//   redirect_i     flush everything in flight and jump
//   redirect_pc_i  new PC when redirect_i=1
//   inst_valid_o   FIFO head valid
//   inst_ready_i   decode accepts the head
//   inst_o         instruction word
//   inst_pc_o      PC of inst_o
//   inst_fault_o   head word came from an unmapped address
// Modports: master = fetch stage, slave = memory/decode environment.
// -----------------------------------------------------------------------------
interface inst_fetch_if #(
  parameter int WORDSIZE = 16
);
  logic [WORDSIZE-1:0] mem_addr_o;
  logic                mem_hit_i;
  logic [WORDSIZE-1:0] mem_data_i;
  logic                redirect_i;
  logic [WORDSIZE-1:0] redirect_pc_i;
  logic                inst_valid_o;
  logic                inst_ready_i;
  logic [WORDSIZE-1:0] inst_o;
  logic [WORDSIZE-1:0] inst_pc_o;
  logic                inst_fault_o;

  modport master (
    output mem_addr_o,
    input  mem_hit_i,
    input  mem_data_i,
    input  redirect_i,
    input  redirect_pc_i,
    output inst_valid_o,
    input  inst_ready_i,
    output inst_o,
    output inst_pc_o,
    output inst_fault_o
  );

  modport slave (
    input  mem_addr_o,
    output mem_hit_i,
    output mem_data_i,
    output redirect_i,
    output redirect_pc_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  inst_o,
    input  inst_pc_o,
    input  inst_fault_o
  );
endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Purpose : instruction fetch stage in front of memblock read port 2. Holds the
//           PC, issues one word address per cycle, captures the returning word
//           one cycle later and buffers {word, pc, fault} in a small FIFO that
//           decode drains with valid/ready. A redirect squashes everything in
//           flight and restarts fetch at a new PC.
// Ports   :
//   clk   in   clock, all state on posedge
//   rst   in   synchronous reset, active-high
//   bus   inst_fetch_if.master (memory read port, redirect, decode handshake)
// Params  : WORDSIZE (data/address width), RESET_PC (PC after reset),
//           DEPTH (FIFO entries, power of 2, >=2; >=4 sustains 1 word/cycle)
// Config  : define FETCH_BYPASS_EN to present a freshly returned word directly
//           on inst_* when the FIFO is empty (latency 1 instead of 2). Without
//           it every word passes through the FIFO and there is no
//           mem_data_i -> inst_o combinational path.
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int                  WORDSIZE = 16,
  parameter logic [WORDSIZE-1:0] RESET_PC = {WORDSIZE{1'b0}},
  parameter int                  DEPTH    = 4
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  localparam int              PW      = $clog2(DEPTH);
  localparam logic [PW+1:0]   DEPTH_C = (PW+2)'(DEPTH);
  localparam logic [PW:0]     FULL_C  = (PW+1)'(DEPTH);

  typedef struct packed {
    logic                fault;
    logic [WORDSIZE-1:0] pc;
    logic [WORDSIZE-1:0] data;
  } entry_t;

  logic [WORDSIZE-1:0] r_pc;
  logic                r_inflight;
  logic [WORDSIZE-1:0] r_lat_pc;
  logic                r_lat_hit;
  entry_t              r_fifo [DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [PW:0]         r_count;

  logic [PW+1:0]       w_credit;
  logic                w_issue;
  logic                w_push;
  logic                w_empty;
  logic                w_valid;
  logic                w_fifo_wr;
  logic                w_fifo_rd;
  entry_t              w_push_ent;
  entry_t              w_out;

  // Issue credit, push/pop decisions and head selection.
  always_comb begin
    // Credit uses registered count/inflight, so a pop frees a slot next cycle.
    w_credit   = {1'b0, r_count} + {{(PW+1){1'b0}}, r_inflight};
    w_issue    = !bus.redirect_i && (w_credit < DEPTH_C);
    w_push     = r_inflight && !bus.redirect_i;
    w_empty    = (r_count == {(PW+1){1'b0}});
    w_push_ent = '{fault: !r_lat_hit, pc: r_lat_pc, data: bus.mem_data_i};
`ifdef FETCH_BYPASS_EN
    w_valid = !bus.redirect_i && (!w_empty || w_push);
    if (w_empty) begin
      w_out = w_push_ent;
    end else begin
      w_out = r_fifo[r_rptr];
    end
    w_fifo_rd = w_valid && bus.inst_ready_i && !w_empty;
    // A bypassed word that decode takes immediately never enters the FIFO.
    w_fifo_wr = w_push && !(w_empty && bus.inst_ready_i);
`else
    w_valid   = !bus.redirect_i && !w_empty;
    w_out     = r_fifo[r_rptr];
    w_fifo_rd = w_valid && bus.inst_ready_i;
    w_fifo_wr = w_push;
`endif
  end

  // Decode-side outputs, forced to zero whenever no head is presented.
  always_comb begin
    bus.inst_valid_o = w_valid;
    if (w_valid) begin
      bus.inst_o       = w_out.data;
      bus.inst_pc_o    = w_out.pc;
      bus.inst_fault_o = w_out.fault;
    end else begin
      bus.inst_o       = {WORDSIZE{1'b0}};
      bus.inst_pc_o    = {WORDSIZE{1'b0}};
      bus.inst_fault_o = 1'b0;
    end
  end

  assign bus.mem_addr_o = r_pc;

  // PC, in-flight tracking and FIFO pointer/count state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_lat_pc   <= {WORDSIZE{1'b0}};
      r_lat_hit  <= 1'b0;
      r_wptr     <= {PW{1'b0}};
      r_rptr     <= {PW{1'b0}};
      r_count    <= {(PW+1){1'b0}};
    end else if (bus.redirect_i) begin
      r_pc       <= bus.redirect_pc_i;
      r_inflight <= 1'b0;
      r_lat_pc   <= {WORDSIZE{1'b0}};
      r_lat_hit  <= 1'b0;
      r_wptr     <= {PW{1'b0}};
      r_rptr     <= {PW{1'b0}};
      r_count    <= {(PW+1){1'b0}};
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc      <= r_pc + WORDSIZE'(1);
        r_lat_pc  <= r_pc;
        r_lat_hit <= bus.mem_hit_i;
      end else begin
        r_pc      <= r_pc;
        r_lat_pc  <= r_lat_pc;
        r_lat_hit <= r_lat_hit;
      end
      if (w_fifo_wr) begin
        r_wptr <= r_wptr + PW'(1);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_fifo_rd) begin
        r_rptr <= r_rptr + PW'(1);
      end else begin
        r_rptr <= r_rptr;
      end
      case ({w_fifo_wr, w_fifo_rd})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful below r_count, so no reset.
  always_ff @(posedge clk) begin
    if (w_fifo_wr && !rst) begin
      r_fifo[r_wptr] <= w_push_ent;
    end
  end

  inst_fetch_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_full (r_count == FULL_C)
  );

endmodule

// -----------------------------------------------------------------------------
// inst_fetch_chk
// Purpose : property checks for inst_fetch; issue credit must keep a returning
//           word from ever arriving while the FIFO is full.
// Ports   : clk, rst, i_push (word returning this cycle), i_full (FIFO full)
// -----------------------------------------------------------------------------
module inst_fetch_chk (
  input logic clk,
  input logic rst,
  input logic i_push,
  input logic i_full
);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(i_push && i_full));
endmodule

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
module tb_inst_fetch;
  localparam int          WS       = 16;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0010;
`ifdef FETCH_BYPASS_EN
  localparam int          LAT      = 1;
`else
  localparam int          LAT      = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_if #(.WORDSIZE(WS)) bus ();

  inst_fetch #(.WORDSIZE(WS), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory map: 0x0300..0x03FF is unmapped, everything else holds a hash.
  function automatic logic mapped(input logic [15:0] a);
    return a[15:8] != 8'h03;
  endfunction

  function automatic logic [15:0] memval(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  assign bus.mem_hit_i = mapped(bus.mem_addr_o);
  always @(posedge clk) bus.mem_data_i <= memval(bus.mem_addr_o);

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the delivered stream is simply consecutive PCs from the
  // last reset/redirect target; stalls and throughput follow from DEPTH/LAT.
  logic [15:0] exp_pc;
  logic [15:0] restart_pc;
  int          k;
  bit          all_ready;
  int          stall_run;

  task automatic restart(input logic [15:0] p);
    exp_pc     = p;
    restart_pc = p;
    k          = 0;
    all_ready  = 1'b1;
    stall_run  = 0;
  endtask

  task automatic run_cycle(input bit r, input bit rd, input logic [15:0] rpc, input bit rdy);
    logic [15:0] stall_pc;
    rst               = r;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    bus.inst_ready_i  = rdy;
    @(negedge clk);
    if (r) begin
      restart(RESET_PC);
    end else begin
      if (k == 0) chk("restart_addr", 64'(bus.mem_addr_o), 64'(restart_pc));
      if (rd) begin
        chk("redirect_quiet", 64'({bus.inst_valid_o, bus.inst_o, bus.inst_pc_o, bus.inst_fault_o}), 64'd0);
        restart(rpc);
      end else begin
        if (all_ready) chk("stream_valid", 64'(bus.inst_valid_o), 64'(k >= LAT));
        if (stall_run >= DEPTH + 2) begin
          stall_pc = exp_pc + 16'(DEPTH);
          chk("stall_addr", 64'(bus.mem_addr_o), 64'(stall_pc));
          chk("stall_valid", 64'(bus.inst_valid_o), 64'd1);
        end
        if (bus.inst_valid_o) begin
          if (rdy) begin
            chk("inst_pc", 64'(bus.inst_pc_o), 64'(exp_pc));
            chk("inst_fault", 64'(bus.inst_fault_o), 64'(!mapped(exp_pc)));
            if (mapped(exp_pc)) chk("inst_data", 64'(bus.inst_o), 64'(memval(exp_pc)));
            exp_pc = exp_pc + 16'd1;
          end
        end else begin
          chk("idle_zero", 64'({bus.inst_o, bus.inst_pc_o, bus.inst_fault_o}), 64'd0);
        end
        if (!rdy) begin
          all_ready = 1'b0;
          stall_run++;
        end else begin
          stall_run = 0;
        end
        k++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          r;
    bit          rd;
    bit          rdy;
    logic [15:0] rpc;
    int          stall_left;
    rst               = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 16'h0000;
    bus.inst_ready_i  = 1'b0;
    restart(RESET_PC);

    // Reset, then free-running fetch from RESET_PC.
    run_cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    run_cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    repeat (20) run_cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Back-pressure fills the FIFO, then drains in order.
    repeat (10) run_cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    repeat (10) run_cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Redirect while FIFO holds words and one is in flight.
    run_cycle(1'b0, 1'b1, 16'h0100, 1'b1);
    repeat (4) run_cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    run_cycle(1'b0, 1'b1, 16'h0200, 1'b1);
    repeat (8) run_cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // PC wrap at the top of the address space.
    run_cycle(1'b0, 1'b1, 16'hFFFC, 1'b1);
    repeat (10) run_cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Entering and leaving the unmapped window.
    run_cycle(1'b0, 1'b1, 16'h02FD, 1'b1);
    repeat (10) run_cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    run_cycle(1'b0, 1'b1, 16'h03FD, 1'b1);
    repeat (10) run_cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Reset with a valid head and a word in flight.
    repeat (3) run_cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    run_cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    repeat (6) run_cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Randomized traffic.
    stall_left = 0;
    repeat (800) begin
      r  = ($urandom_range(0, 79) == 0);
      rd = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = 16'($urandom);
        1:       rpc = 16'hFFF8 + 16'($urandom_range(0, 7));
        2:       rpc = 16'h02F8 + 16'($urandom_range(0, 7));
        default: rpc = 16'h03F8 + 16'($urandom_range(0, 7));
      endcase
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 39) == 0) stall_left = 8;
      end
      run_cycle(r, rd, rpc, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
